// File: rtl/spi_read_byte_fifo_pkg.sv
// Shared SPI read-path types: byte width and the {last, data} entry carried
// from the read engine through the byte FIFO to the readback mux.
package spi_read_byte_fifo_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef struct packed {
    logic                  last;
    logic [SPI_BYTE_W-1:0] data;
  } spi_rd_entry_t;

endpackage

// File: rtl/spi_read_byte_fifo_if.sv
// AXI-Stream style byte stream (valid/ready/last) leaving the SPI read FIFO.
// Beat transfers when m_tvalid && m_tready; the master holds data while stalled.
interface spi_read_byte_fifo_if
  import spi_read_byte_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_BYTE_W
);

  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tlast;
  logic                  m_tready;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);

endinterface

// File: rtl/spi_read_byte_fifo_sync_fifo.sv
// Generic show-ahead synchronous FIFO: head entry visible the cycle after its push.
// A push into a full FIFO is accepted only alongside a pop; flush wins over both.
module spi_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_dat_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  // Head reads as zero while empty so nothing stale leaks onto the bus.
  assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      level_d = level_q + (AW+1)'(1);
      else if (!push_ok && pop_ok) level_d = level_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/spi_read_byte_fifo.sv
// Captures engine bytes on strobe rising edges, tags burst-final bytes, buffers them
// and streams them out (1 cycle strobe-to-tvalid); full FIFO drops and flags overflow.
module spi_read_byte_fifo
  import spi_read_byte_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_BYTE_W,
  parameter int DEPTH      = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [DATA_WIDTH-1:0]     byte_data_in,
  input  logic                      byte_strobe_in,
  input  logic                      burst_done_in,
  input  logic                      flush,
  spi_read_byte_fifo_if.master      m_axis,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      overflow,
  output logic                      proto_err
);

  logic          strobe_q, done_q, armed_q;
  logic          overflow_q, overflow_d;
  logic          proto_err_q, proto_err_d;
  logic          wr_req, done_rise, pop, drop;
  logic          fifo_full, fifo_empty;
  spi_rd_entry_t wr_entry, head;

  // armed_q masks the first edge after reset so a strobe still held high is
  // absorbed into strobe_q instead of looking like a fresh rising edge.
  assign wr_req    = armed_q & byte_strobe_in & ~strobe_q;
  assign done_rise = armed_q & burst_done_in & ~done_q;

  assign wr_entry.last = done_rise;
  assign wr_entry.data = byte_data_in;

  assign pop  = ~fifo_empty & m_axis.m_tready;
  assign drop = wr_req & fifo_full & ~pop;

  spi_sync_fifo #(
    .WIDTH ($bits(spi_rd_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .flush_i    (flush),
    .push_i     (wr_req),
    .push_dat_i (wr_entry),
    .pop_i      (pop),
    .head_dat_o (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level)
  );

  assign m_axis.m_tvalid = ~fifo_empty;
  assign m_axis.m_tdata  = head.data;
  assign m_axis.m_tlast  = head.last;
  assign overflow        = overflow_q;
  assign proto_err       = proto_err_q;

  always_comb begin
    overflow_d  = overflow_q | drop;
    proto_err_d = proto_err_q | (done_rise & ~wr_req);
    if (flush) begin
      overflow_d  = 1'b0;
      proto_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      strobe_q    <= 1'b0;
      done_q      <= 1'b0;
      armed_q     <= 1'b0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      strobe_q    <= byte_strobe_in;
      done_q      <= burst_done_in;
      armed_q     <= 1'b1;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_spi_read_byte_fifo.sv
// Directed bench for spi_read_byte_fifo: inputs driven and outputs sampled on the falling edge.
module tb_spi_read_byte_fifo;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] byte_data_in;
  logic       byte_strobe_in;
  logic       burst_done_in;
  logic       flush;
  logic [4:0] fifo_level;
  logic       overflow;
  logic       proto_err;

  int n_chk  = 0;
  int n_fail = 0;

  spi_read_byte_fifo_if #(.DATA_WIDTH(8)) axis ();

  spi_read_byte_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .byte_data_in   (byte_data_in),
    .byte_strobe_in (byte_strobe_in),
    .burst_done_in  (burst_done_in),
    .flush          (flush),
    .m_axis         (axis),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .proto_err      (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One-cycle strobe pulse; the write lands on the rising edge inside the pulse.
  task automatic push_byte(input logic [7:0] d, input logic last);
    byte_strobe_in = 1'b1;
    byte_data_in   = d;
    burst_done_in  = last;
    tick();
    byte_strobe_in = 1'b0;
    burst_done_in  = 1'b0;
  endtask

  initial begin
    rstn           = 1'b0;
    byte_data_in   = 8'h00;
    byte_strobe_in = 1'b0;
    burst_done_in  = 1'b0;
    flush          = 1'b0;
    axis.m_tready  = 1'b0;
    repeat (2) tick();

    chk("rst_tvalid", 32'(axis.m_tvalid), 32'd0);
    chk("rst_tlast",  32'(axis.m_tlast),  32'd0);
    chk("rst_tdata",  32'(axis.m_tdata),  32'd0);
    chk("rst_level",  32'(fifo_level),    32'd0);
    chk("rst_ovf",    32'(overflow),      32'd0);
    chk("rst_perr",   32'(proto_err),     32'd0);
    rstn = 1'b1;
    tick();

    // 1: three-byte burst, consumer always ready
    axis.m_tready = 1'b1;
    push_byte(8'hA5, 1'b0);
    chk("t1_b0_vld",  32'(axis.m_tvalid), 32'd1);
    chk("t1_b0_dat",  32'(axis.m_tdata),  32'hA5);
    chk("t1_b0_last", 32'(axis.m_tlast),  32'd0);
    tick();
    chk("t1_b0_pop_lvl", 32'(fifo_level), 32'd0);
    push_byte(8'h3C, 1'b0);
    chk("t1_b1_dat",  32'(axis.m_tdata),  32'h3C);
    chk("t1_b1_last", 32'(axis.m_tlast),  32'd0);
    tick();
    push_byte(8'h7E, 1'b1);
    chk("t1_b2_dat",  32'(axis.m_tdata),  32'h7E);
    chk("t1_b2_last", 32'(axis.m_tlast),  32'd1);
    tick();
    chk("t1_end_lvl",  32'(fifo_level),    32'd0);
    chk("t1_end_vld",  32'(axis.m_tvalid), 32'd0);
    chk("t1_end_perr", 32'(proto_err),     32'd0);

    // 2: fill with 1..16 while stalled, 17th byte dropped
    axis.m_tready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      push_byte(8'(i), 1'b0);
      tick();
    end
    chk("t2_full_lvl", 32'(fifo_level), 32'd16);
    chk("t2_full_ovf", 32'(overflow),   32'd0);
    push_byte(8'hFF, 1'b0);
    tick();
    chk("t2_drop_lvl",  32'(fifo_level),    32'd16);
    chk("t2_drop_ovf",  32'(overflow),      32'd1);
    chk("t2_hold_dat",  32'(axis.m_tdata),  32'h01);
    axis.m_tready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("t2_drain_%0d", i), 32'(axis.m_tdata), 32'(i));
      tick();
    end
    chk("t2_empty_vld", 32'(axis.m_tvalid), 32'd0);
    chk("t2_empty_lvl", 32'(fifo_level),    32'd0);
    chk("t2_ovf_sticky", 32'(overflow),     32'd1);

    // 3: full FIFO, push and pop together
    axis.m_tready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t3_flush_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      push_byte(8'h30 + 8'(i), 1'b0);
      tick();
    end
    chk("t3_full_lvl", 32'(fifo_level), 32'd16);
    axis.m_tready = 1'b1;
    push_byte(8'hEE, 1'b0);
    chk("t3_pp_lvl",  32'(fifo_level),   32'd16);
    chk("t3_pp_ovf",  32'(overflow),     32'd0);
    chk("t3_pp_head", 32'(axis.m_tdata), 32'h31);
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("t3_drain_%0d", j), 32'(axis.m_tdata),
          (j < 15) ? 32'h31 + 32'(j) : 32'hEE);
      tick();
    end
    chk("t3_end_lvl", 32'(fifo_level), 32'd0);
    axis.m_tready = 1'b0;

    // 4: strobe held high writes once
    byte_strobe_in = 1'b1;
    byte_data_in   = 8'h11;
    repeat (5) tick();
    byte_strobe_in = 1'b0;
    chk("t4_lvl", 32'(fifo_level),   32'd1);
    chk("t4_dat", 32'(axis.m_tdata), 32'h11);
    tick();
    chk("t4_lvl_after", 32'(fifo_level), 32'd1);

    // 5: done with no byte, then flush
    burst_done_in = 1'b1;
    tick();
    burst_done_in = 1'b0;
    chk("t5_perr", 32'(proto_err),  32'd1);
    chk("t5_lvl",  32'(fifo_level), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_flush_perr", 32'(proto_err),     32'd0);
    chk("t5_flush_lvl",  32'(fifo_level),    32'd0);
    chk("t5_flush_vld",  32'(axis.m_tvalid), 32'd0);

    // 6: reset mid-burst with strobe held high across release
    for (int i = 0; i < 5; i++) begin
      push_byte(8'h60 + 8'(i), 1'b0);
      tick();
    end
    chk("t6_pre_lvl", 32'(fifo_level), 32'd5);
    byte_strobe_in = 1'b1;
    byte_data_in   = 8'h55;
    rstn           = 1'b0;
    #1;
    chk("t6_rst_lvl", 32'(fifo_level),    32'd0);
    chk("t6_rst_vld", 32'(axis.m_tvalid), 32'd0);
    repeat (2) tick();
    rstn = 1'b1;
    repeat (2) tick();
    chk("t6_rel_lvl", 32'(fifo_level),    32'd0);
    chk("t6_rel_vld", 32'(axis.m_tvalid), 32'd0);
    byte_strobe_in = 1'b0;
    tick();
    byte_strobe_in = 1'b1;
    tick();
    byte_strobe_in = 1'b0;
    chk("t6_rearm_lvl", 32'(fifo_level),    32'd1);
    chk("t6_rearm_vld", 32'(axis.m_tvalid), 32'd1);
    chk("t6_rearm_dat", 32'(axis.m_tdata),  32'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
